// File: rtl/fft_pkg.sv
// Definitions shared by the FFT controller and the FFT stage modules:
// frame size, sample width, controller states and the 3-bit bit-reversal.
package fft_pkg;

    localparam int N  = 8;
    localparam int DW = 12;

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        WAIT,
        DRAIN
    } state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_ctrl.sv
// Frame controller around a 3-stage 8-point FFT: gathers 8 samples in
// bit-reversed order, launches the FFT, watches for completion and streams the bins out.
module fft_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DW             = 12
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_image,
    output logic signed [DW-1:0] x_in_real  [0:7],
    output logic signed [DW-1:0] x_in_image [0:7],
    output logic                 start,
    input  logic                 stage3_done,
    input  logic signed [DW-1:0] y_real     [0:7],
    input  logic signed [DW-1:0] y_image    [0:7],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_image,
    output logic [2:0]           out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 timeout_err
);

    import fft_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state;
    logic [2:0]           sample_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic signed [DW-1:0] buf_real  [0:7];
    logic signed [DW-1:0] buf_image [0:7];

    // The timeout counter also counts the FIRE cycle, so it measures
    // cycles elapsed since the start pulse rather than since WAIT entry.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= LOAD;
            sample_cnt  <= '0;
            tmo_cnt     <= '0;
            in_ready    <= 1'b0;
            start       <= 1'b0;
            out_valid   <= 1'b0;
            out_real    <= '0;
            out_image   <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_in_real[i]  <= '0;
                x_in_image[i] <= '0;
                buf_real[i]   <= '0;
                buf_image[i]  <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    tmo_cnt  <= '0;
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        x_in_real[bitrev3(sample_cnt)]  <= in_real;
                        x_in_image[bitrev3(sample_cnt)] <= in_image;
                        sample_cnt <= sample_cnt + 3'd1;
                        if (sample_cnt == 3'd7) begin
                            state    <= FIRE;
                            start    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end

                FIRE: begin
                    start   <= 1'b0;
                    tmo_cnt <= tmo_cnt + TW'(1);
                    state   <= WAIT;
                end

                WAIT: begin
                    if (stage3_done) begin
                        for (int i = 0; i < N; i++) begin
                            buf_real[i]  <= y_real[i];
                            buf_image[i] <= y_image[i];
                        end
                        out_real  <= y_real[0];
                        out_image <= y_image[0];
                        out_index <= 3'd0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= DRAIN;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        sample_cnt  <= '0;
                        tmo_cnt     <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= LOAD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (out_index == 3'd7) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= 3'd0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            out_index <= out_index + 3'd1;
                            out_real  <= buf_real[out_index + 3'd1];
                            out_image <= buf_image[out_index + 3'd1];
                            out_last  <= (out_index == 3'd6);
                        end
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: table of frames plus hand-written
// sequences for timeout, done-on-limit and mid-frame reset.
module tb_fft_ctrl;

    localparam int DW  = 12;
    localparam int TMO = 16;

    logic                 CLK = 1'b0;
    logic                 nRESET = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_real = '0;
    logic signed [DW-1:0] in_image = '0;
    logic signed [DW-1:0] x_in_real  [0:7];
    logic signed [DW-1:0] x_in_image [0:7];
    logic                 start;
    logic                 stage3_done = 1'b0;
    logic signed [DW-1:0] y_real     [0:7];
    logic signed [DW-1:0] y_image    [0:7];
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_image;
    logic [2:0]           out_index;
    logic                 out_last;
    logic                 busy;
    logic                 timeout_err;

    fft_ctrl #(.TIMEOUT_CYCLES(TMO), .DW(DW)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_image(in_image),
        .x_in_real(x_in_real), .x_in_image(x_in_image),
        .start(start), .stage3_done(stage3_done),
        .y_real(y_real), .y_image(y_image),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_image(out_image),
        .out_index(out_index), .out_last(out_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
    } exp_t;

    typedef struct {
        int         br;
        int         bi;
        int         bstep;
        int         ymul;
        int         yim;
        logic [7:0] pat;
        int         delay;
    } frame_t;

    exp_t   sb[$];
    frame_t frames[3];
    int     exp_xr[8];
    int     exp_xi[8];
    int     n_cmp = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // Loads 8 samples with in_valid held high; returns in the start cycle.
    task automatic load_frame(input int br, input int bi, input int bstep);
        chk("load_in_ready", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_real  = DW'(br + k);
            in_image = DW'(bi + k * bstep);
            exp_xr[rev3(k)] = br + k;
            exp_xi[rev3(k)] = bi + k * bstep;
            step();
            if (k < 7) begin
                chk("start_early", start, 0);
                chk("in_ready_load", in_ready, 1);
            end
        end
        in_real  = DW'(-555);
        in_image = DW'(777);
        chk("start_pulse", start, 1);
        chk("busy_fire", busy, 1);
        chk("in_ready_fire", in_ready, 0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("x_in_real[%0d]", j), x_in_real[j], exp_xr[j]);
            chk($sformatf("x_in_image[%0d]", j), x_in_image[j], exp_xi[j]);
        end
    endtask

    task automatic finish_frame(input int delay, input int ymul, input int yim,
                                input logic [7:0] pat);
        int cycles;
        step();
        chk("start_one_cycle", start, 0);
        for (int c = 1; c < delay; c++) begin
            chk("no_out_in_wait", out_valid, 0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            y_real[i]  = DW'(ymul * i);
            y_image[i] = DW'(yim * (i + 1));
            sb.push_back('{ymul * i, yim * (i + 1), i, (i == 7) ? 1 : 0});
        end
        stage3_done = 1'b1;
        step();
        stage3_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            y_real[i]  = DW'(-1);
            y_image[i] = DW'(-1);
        end
        chk("drain_entry", out_valid, 1);
        cycles = 0;
        while (sb.size() > 0 && cycles < 64) begin
            out_ready = pat[cycles % 8];
            chk("out_valid_drain", out_valid, 1);
            chk("out_real", out_real, sb[0].re);
            chk("out_image", out_image, sb[0].im);
            chk("out_index", out_index, sb[0].idx);
            chk("out_last", out_last, sb[0].last);
            if (out_valid && out_ready) void'(sb.pop_front());
            step();
            cycles++;
        end
        chk("drain_left", sb.size(), 0);
        sb.delete();
        if (pat == 8'hFF) chk("drain_cycles", cycles, 8);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("busy_after", busy, 0);
        chk("x_in_held", x_in_real[1], exp_xr[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            y_real[i]  = '0;
            y_image[i] = '0;
        end
        frames[0] = '{1, 0, 0, 10, 0, 8'hFF, 3};
        frames[1] = '{-100, 50, -3, -7, 3, 8'b1001_1001, 3};
        frames[2] = '{2040, -2048, 1, 255, -1, 8'b0101_0101, 5};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_start", start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_out_index", out_index, 0);
        for (int i = 0; i < 8; i++) chk("rst_x_in", x_in_real[i], 0);
        nRESET = 1'b1;
        step();
        chk("in_ready_after_rst", in_ready, 1);

        stage3_done = 1'b1;
        step();
        stage3_done = 1'b0;
        chk("done_in_load_ignored", out_valid, 0);
        chk("done_in_load_busy", busy, 0);

        foreach (frames[f]) begin
            load_frame(frames[f].br, frames[f].bi, frames[f].bstep);
            finish_frame(frames[f].delay, frames[f].ymul, frames[f].yim, frames[f].pat);
        end
        chk("no_err_after_frames", timeout_err, 0);

        // stage3_done on the very cycle the timeout limit is reached
        load_frame(300, -20, 2);
        finish_frame(TMO - 1, 9, -5, 8'hFF);
        chk("limit_done_no_err", timeout_err, 0);

        // reset after five samples
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_real  = DW'(50 + k);
            in_image = '0;
            step();
        end
        chk("partial_loaded", x_in_real[0], 50);
        nRESET = 1'b0;
        #2;
        chk("midrst_x_in0", x_in_real[0], 0);
        chk("midrst_x_in4", x_in_real[4], 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) step();
        chk("midrst_start", start, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        in_valid = 1'b0;
        nRESET = 1'b1;
        step();
        chk("midrst_in_ready_after", in_ready, 1);
        load_frame(-7, 11, 5);
        finish_frame(3, -33, 2, 8'b1001_1001);

        // timeout: stage3_done never arrives
        load_frame(10, 10, 10);
        in_valid = 1'b0;
        repeat (TMO - 1) step();
        chk("tmo_not_yet", timeout_err, 0);
        chk("tmo_busy_wait", busy, 1);
        step();
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_in_ready", in_ready, 1);
        chk("tmo_busy", busy, 0);
        stage3_done = 1'b1;
        step();
        stage3_done = 1'b0;
        chk("late_done_ignored", out_valid, 0);
        load_frame(400, -400, 7);
        finish_frame(3, 100, -100, 8'hFF);
        chk("tmo_err_sticky", timeout_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles from start pulse to stage3_done before the frame is aborted.
REQ-002 Parameter DW, default 12: sample width in bits, signed two's complement.
REQ-003 Port CLK  input  1  single clock; all logic is rising-edge triggered.
REQ-004 Port nRESET  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  input sample valid.
REQ-006 Port in_ready  output  1  controller can accept an input sample.
REQ-007 Port in_real / in_image  input  DW each  input sample, real and imaginary parts.
REQ-008 Port x_in_real / x_in_image  output  DW x [0:7]  bit-reversed frame driven to FFT stage 1.
REQ-009 Port start  output  1  one-cycle pulse that launches FFT stage 1.
REQ-010 Port stage3_done  input  1  one-cycle pulse from the last FFT stage.
REQ-011 Port y_real / y_image  input  DW x [0:7]  FFT stage 3 result arrays.
REQ-012 Port out_valid  output  1  output sample valid.
REQ-013 Port out_ready  input  1  downstream can accept an output sample.
REQ-014 Port out_real / out_image / out_index  output  DW / DW / 3  output sample and its bin number.
REQ-015 Port out_last  output  1  asserted with bin 7.
REQ-016 Port busy  output  1  high in every state except LOAD.
REQ-017 Port timeout_err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have four states, with LOAD as the reset state:
- LOAD: in_ready=1.
- FIRE: start=1 for exactly one cycle.
- WAIT: timeout counter runs.
- DRAIN: out_valid=1.
REQ-019 In LOAD, each in_valid&&in_ready handshake SHALL write sample k (k=0..7, 3-bit counter) to x_in entry bitrev(k): 0,4,2,6,1,5,3,7.
REQ-020 The 8th accepted sample SHALL move the FSM to FIRE on the next edge, so start is asserted the cycle after the 8th handshake.
REQ-021 FIRE SHALL go to WAIT unconditionally after one cycle.
REQ-022 x_in arrays SHALL hold their values from FIRE until the next LOAD write.
REQ-023 In WAIT, stage3_done SHALL capture y_real/y_image into an internal output buffer and move the FSM to DRAIN.
REQ-024 In WAIT, each cycle without stage3_done SHALL increment the timeout counter.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 without stage3_done, the block SHALL set timeout_err, discard the frame and return to LOAD with the sample counter at 0.
REQ-026 If stage3_done arrives in the same cycle the counter reaches its limit, done SHALL win and no error is raised.
REQ-027 stage3_done outside WAIT SHALL be ignored.
REQ-028 In DRAIN, the output SHALL present buffer entry i with out_index=i, i=0..7 in natural order, and i SHALL advance only on out_valid&&out_ready.
REQ-029 out_real/out_image/out_index SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 The handshake with i=7 (out_last=1) SHALL return the FSM to LOAD; in_ready=1 in the cycle after that handshake.
REQ-031 in_ready SHALL be 0 outside LOAD; in_valid is ignored there and no sample is lost or duplicated.
REQ-032 Data SHALL pass through unmodified; the block performs no arithmetic on samples.
REQ-033 timeout_err SHALL be cleared only by reset.

Reset
REQ-034 While nRESET=0, the block SHALL set: state=LOAD, sample counter=0, out index=0, timeout counter=0.
REQ-035 While nRESET=0, the block SHALL drive start=0, out_valid=0, out_last=0, busy=0, timeout_err=0, in_ready=0, and all x_in and buffer entries to 0.
REQ-036 in_ready SHALL be 1 in the first cycle after nRESET deasserts.
REQ-037 Reset asserted mid-frame (any state) SHALL abort the frame immediately, and no start or out_valid SHALL follow from that frame.

Structure
REQ-038 Package fft_pkg SHALL hold the following, shared with the FFT stage modules:
- constants N=8 and DW=12;
- the state enum {LOAD, FIRE, WAIT, DRAIN};
- the bitrev3 function.
REQ-039 The block SHALL be a single module with no sub-module; the output buffer and index mux stay inline.

Verification
REQ-040 Feed samples real=k+1 (k=0..7), image=0, with in_valid held high. Required: x_in_real = {1,5,3,7,2,6,4,8}, start pulses one cycle after the 8th handshake, busy=1.
REQ-041 Return stage3_done 3 cycles after start with y_real[i]=10*i and out_ready=1. Required: out_real = 0,10,..,70 on consecutive cycles, out_index 0..7, out_last only on bin 7, in_ready=1 the next cycle.
REQ-042 Toggle out_ready 1,0,0,1,... during DRAIN. Required: out_* held stable while stalled, all 8 bins delivered exactly once.
REQ-043 Never assert stage3_done, with TIMEOUT_CYCLES=16. Required: timeout_err=1 16 cycles after start, state LOAD, and the next frame processes normally with timeout_err still 1.
REQ-044 Assert stage3_done on the exact timeout cycle. Required: DRAIN entered and timeout_err stays 0.
REQ-045 Pull nRESET low after 5 samples are loaded, then release. Required: all outputs at reset values, and a fresh 8-sample frame yields start after its 8th handshake only.
